// File: rtl/reset_ctrl.sv
// Reset sequencer: synchronizes async_reset_n deassertion, holds a synchronous reset
// for HOLD_CYCLES, then runs. Also provides a retriggerable software reset pulse and clock gating.
module reset_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 8,
    parameter int PULSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       async_reset_n,
    input  logic       i_sw_reset,
    input  logic       i_clk_en,
    output logic       o_rst_n,
    output logic       o_sync_reset,
    output logic       o_clk_enable,
    output logic       o_ready,
    output logic [1:0] o_state
);

    // state  | meaning
    // RESET  | async reset asserted or synchronizer still filling
    // HOLD   | o_rst_n released, sync reset held for HOLD_CYCLES
    // RUN    | downstream out of reset, clock gate follows i_clk_en
    // SWRST  | software reset pulse, retriggered by i_sw_reset
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_SWRST = 2'd3
    } state_t;

    localparam int CNT_MAX = (HOLD_CYCLES > PULSE_CYCLES) ? HOLD_CYCLES : PULSE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_done;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                   clk_en_q, clk_en_d;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_done = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q  <= ST_RESET;
            cnt_q    <= '0;
            clk_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clk_en_q <= clk_en_d;
        end
    end

    // Saturating so the counter can never wrap, even for an out-of-range state.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RESET: begin
                if (sync_done) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                if (i_sw_reset) begin
                    state_d = ST_SWRST;
                    cnt_d   = '0;
                end
            end
            ST_SWRST: begin
                if (i_sw_reset) begin
                    cnt_d = '0;
                end else if (cnt_q == PULSE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Gate enable is registered against the next state so it lines up with o_state.
    always_comb begin
        clk_en_d = 1'b0;
        unique case (state_d)
            ST_RUN:            clk_en_d = i_clk_en;
            ST_HOLD, ST_SWRST: clk_en_d = 1'b1;
            default:           clk_en_d = 1'b0;
        endcase
    end

    always_comb begin
        o_rst_n      = 1'b0;
        o_sync_reset = 1'b1;
        o_ready      = 1'b0;
        unique case (state_q)
            ST_HOLD: begin
                o_rst_n = 1'b1;
            end
            ST_RUN: begin
                o_rst_n      = 1'b1;
                o_sync_reset = 1'b0;
                o_ready      = 1'b1;
            end
            ST_SWRST: begin
                o_rst_n = 1'b1;
            end
            default: begin
                o_rst_n      = 1'b0;
                o_sync_reset = 1'b1;
                o_ready      = 1'b0;
            end
        endcase
    end

    assign o_clk_enable = clk_en_q;
    assign o_state      = state_q;

endmodule
